// File: rtl/srv1_board_pkg.sv
// Shared definitions for the board input controller: register map,
// input count, bus geometry, CTRL layout and the bus FSM state encoding.
package srv1_board_pkg;

    localparam int N_INPUTS = 14;
    localparam int BUS_AW   = 2;
    localparam int BUS_DW   = 32;

    localparam logic [BUS_AW-1:0] REG_LEVEL = 2'd0;
    localparam logic [BUS_AW-1:0] REG_EDGE  = 2'd1;
    localparam logic [BUS_AW-1:0] REG_MASK  = 2'd2;
    localparam logic [BUS_AW-1:0] REG_CTRL  = 2'd3;

    typedef struct packed {
        logic [29:0] rsvd;
        logic        freeze;
        logic        enable;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{rsvd: '0, freeze: 1'b0, enable: 1'b1};

    typedef enum logic [0:0] {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_t;

endpackage

// File: rtl/board_input_ctrl_if.sv
// Register bus between the CPU side (master) and the board input
// controller (slave), plus the interrupt line back to the CPU.
//
// Handshake: bus_req is a single-cycle request sampled on the rising clock
// edge together with bus_we/bus_addr/bus_wdata. The slave answers with
// bus_ack high for exactly the following cycle, with bus_rdata valid in
// that cycle and zero otherwise. A new request may be issued in the ack
// cycle; it is acked in the cycle after. No request is ever held pending.
interface board_input_ctrl_if;
    import srv1_board_pkg::*;

    logic              bus_req;
    logic              bus_we;
    logic [BUS_AW-1:0] bus_addr;
    logic [BUS_DW-1:0] bus_wdata;
    logic [BUS_DW-1:0] bus_rdata;
    logic              bus_ack;
    logic              irq;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack, irq
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack, irq
    );

endinterface

// File: rtl/board_input_ctrl_debouncer.sv
// One-bit synchroniser + debouncer. The debounced level only follows the
// synchronised input after it has differed from it for DEBOUNCE_CYCLES
// consecutive cycles; rise_pulse marks a 0->1 change of that level.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic async_rst,
    input  logic din,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic                   stable_q;
    logic                   stable_d_q;
    logic [CW-1:0]          cnt_q;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // Synchroniser chain; resets to the inactive level.
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) sync_q <= '0;
        else            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end

    // Count consecutive disagreeing samples; adopt the new level at CNT_MAX,
    // so the counter restarts before it could wrap.
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else if (sync_bit == stable_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_q <= sync_bit;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Delayed copy of the level for one-cycle rise detection.
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) stable_d_q <= 1'b0;
        else            stable_d_q <= stable_q;
    end

    assign level      = stable_q;
    assign rise_pulse = stable_q & ~stable_d_q;

endmodule

// File: rtl/board_input_ctrl.sv
// Board input controller: debounces switches and push buttons, latches
// rising edges in a sticky W1C register and exposes LEVEL/EDGE/MASK/CTRL
// on a single-cycle request/ack register bus.
// Optional feature macro: BOARD_INPUT_IRQ_EN (MASK register + level irq).
module board_input_ctrl
    import srv1_board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 1000,
    parameter bit BUTTON_ACTIVE_LOW = 1'b1,
    parameter int SYNC_STAGES       = 2
) (
    input  logic               clk,
    input  logic               async_rst,
    input  logic [9:0]         switches,
    input  logic [3:0]         push_buttons,
    board_input_ctrl_if.slave  bus,
    output bus_state_t         dbg_state
);

    logic [N_INPUTS-1:0] raw_in;
    logic [N_INPUTS-1:0] stable_vec;
    logic [N_INPUTS-1:0] rise_vec;
    logic [N_INPUTS-1:0] frozen_q;
    logic [N_INPUTS-1:0] level_vec;
    logic [N_INPUTS-1:0] edge_q;
    logic [N_INPUTS-1:0] edge_clr;
    logic [N_INPUTS-1:0] mask_vec;
    ctrl_t               ctrl_q;
    bus_state_t          state_q, state_d;
    logic [BUS_DW-1:0]   rd_mux;
    logic [BUS_DW-1:0]   rdata_q;
    logic                wr_en;
    logic                unused_wdata;

    // Buttons are inverted ahead of the synchroniser so that a pressed
    // button is 1 and the reset value 0 is the inactive level.
    assign raw_in = {(BUTTON_ACTIVE_LOW ? ~push_buttons : push_buttons), switches};
    assign wr_en  = bus.bus_req & bus.bus_we;
    assign unused_wdata = ^bus.bus_wdata[BUS_DW-1:N_INPUTS];

    genvar g;
    generate
        for (g = 0; g < N_INPUTS; g++) begin : g_deb
            input_debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .SYNC_STAGES     (SYNC_STAGES)
            ) u_deb (
                .clk        (clk),
                .async_rst  (async_rst),
                .din        (raw_in[g]),
                .level      (stable_vec[g]),
                .rise_pulse (rise_vec[g])
            );
        end
    endgenerate

    // Snapshot of the level while not frozen; LEVEL shows it when frozen.
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst)          frozen_q <= '0;
        else if (!ctrl_q.freeze) frozen_q <= stable_vec;
    end

    assign level_vec = ctrl_q.freeze ? frozen_q : stable_vec;
    assign edge_clr  = (wr_en && bus.bus_addr == REG_EDGE) ? bus.bus_wdata[N_INPUTS-1:0] : '0;

    // Sticky edge capture; a new rise in the clearing cycle survives.
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) edge_q <= '0;
        else            edge_q <= (edge_q & ~edge_clr) | (rise_vec & {N_INPUTS{ctrl_q.enable}});
    end

    // CTRL register; reserved bits always hold zero.
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst)                                ctrl_q <= CTRL_RESET;
        else if (wr_en && bus.bus_addr == REG_CTRL)    ctrl_q <= ctrl_t'({30'h0, bus.bus_wdata[1:0]});
    end

`ifdef BOARD_INPUT_IRQ_EN
    logic [N_INPUTS-1:0] mask_q;
    logic                irq_q;

    // Interrupt mask register.
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst)                             mask_q <= '0;
        else if (wr_en && bus.bus_addr == REG_MASK) mask_q <= bus.bus_wdata[N_INPUTS-1:0];
    end

    // Registered level interrupt: one cycle behind the EDGE register.
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) irq_q <= 1'b0;
        else            irq_q <= (|(edge_q & mask_q)) & ctrl_q.enable;
    end

    assign mask_vec = mask_q;
    assign bus.irq  = irq_q;
`else
    assign mask_vec = '0;
    assign bus.irq  = 1'b0;
`endif

    // Bus FSM state register; reset drops any access in flight.
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) state_q <= BUS_IDLE;
        else            state_q <= state_d;
    end

    // Bus FSM next state: every request leads to exactly one ack cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE: if (bus.bus_req) state_d = BUS_ACK;
            BUS_ACK:  state_d = bus.bus_req ? BUS_ACK : BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    // Read data selection for the addressed register.
    always_comb begin
        rd_mux = '0;
        case (bus.bus_addr)
            REG_LEVEL: rd_mux = {{(BUS_DW-N_INPUTS){1'b0}}, level_vec};
            REG_EDGE:  rd_mux = {{(BUS_DW-N_INPUTS){1'b0}}, edge_q};
            REG_MASK:  rd_mux = {{(BUS_DW-N_INPUTS){1'b0}}, mask_vec};
            REG_CTRL:  rd_mux = ctrl_q;
            default:   rd_mux = '0;
        endcase
    end

    // Read data is captured in the request cycle and is zero otherwise.
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst)       rdata_q <= '0;
        else if (bus.bus_req) rdata_q <= rd_mux;
        else                  rdata_q <= '0;
    end

    assign bus.bus_ack   = (state_q == BUS_ACK);
    assign bus.bus_rdata = rdata_q;
    assign dbg_state     = state_q;

endmodule
